fifo_rd_stream: RTL and testbench

//  Read-side consumer for the dual-clock FIFO: converts its read/empty/dout interface into valid/ready.
//  - FIFO read data appears one r_clk after the read strobe, so reads are issued ahead into a 3-entry

---
 rtl/fifo_rd_stream_pkg.sv | 18 +
 rtl/fifo_rd_stream_if.sv | 32 +++
 rtl/fifo_out_ring.sv | 63 ++++++
 rtl/fifo_rd_stream.sv | 79 +++++++
 tb/tb_fifo_rd_stream.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter.
// Output buffer depth, pointer/occupancy types and pointer wrap helper.
package fifo_rd_stream_pkg;

  localparam int OB_DEPTH = 3;

  typedef logic [1:0] ob_ptr_t;
  typedef logic [1:0] ob_occ_t;

  function automatic ob_ptr_t ob_ptr_inc(
    input ob_ptr_t p
  );
    if (p == ob_ptr_t'(OB_DEPTH - 1))
      return '0;
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream bundle.
// master = the adapter, slave = FIFO/downstream side.
interface fifo_rd_stream_if #(
  parameter int DW = 8
);

  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd,
    output m_data,
    output m_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd,
    input  m_data,
    input  m_valid
  );

endinterface

// File: rtl/fifo_out_ring.sv
// Three-entry register ring: storage, wrap-at-2 pointers, occupancy.
// Head data is a mux of registers only; no bypass from push_data.
module fifo_out_ring
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output ob_occ_t       occ
);

  logic [DW-1:0] mem_q [OB_DEPTH];
  ob_ptr_t       wr_ptr_q, wr_ptr_d;
  ob_ptr_t       rd_ptr_q, rd_ptr_d;
  ob_occ_t       occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push)
      wr_ptr_d = ob_ptr_inc(wr_ptr_q);
    if (pop)
      rd_ptr_d = ob_ptr_inc(rd_ptr_q);
    unique case (1'b1)
      (push && !pop): occ_d = occ_q + 2'd1;
      (pop && !push): occ_d = occ_q - 2'd1;
      default:        occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OB_DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int i = 0; i < OB_DEPTH; i++)
        if (push && wr_ptr_q == ob_ptr_t'(i))
          mem_q[i] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_comb begin
    head_data = mem_q[0];
    for (int i = 1; i < OB_DEPTH; i++)
      if (rd_ptr_q == ob_ptr_t'(i))
        head_data = mem_q[i];
  end

  assign occ = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read/empty/dout to valid/ready adapter, read clock domain.
// FIFO_RD_STATS_EN adds a saturating accepted-beat counter port.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FIFO_RD_STATS_EN
  output logic [CNT_W-1:0] beat_cnt,
`endif
  fifo_rd_stream_if.master bus
);

  logic          rd_dly_q, rd_dly_d;
  logic          pop;
  logic [DW-1:0] head;
  ob_occ_t       occ;
  logic [2:0]    occ_sum;

  // Count in-flight reads as occupied so the ring can never overflow.
  assign occ_sum = {1'b0, occ} + {2'b0, rd_dly_q};

  assign bus.fifo_rd = !rst && !bus.fifo_empty
                    && (occ_sum < 3'(OB_DEPTH));
  assign rd_dly_d    = bus.fifo_rd;

  always_ff @(posedge clk) begin
    if (rst)
      rd_dly_q <= 1'b0;
    else
      rd_dly_q <= rd_dly_d;
  end

  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = head;
  assign pop         = bus.m_valid && bus.m_ready;

  fifo_out_ring #(
    .DW(DW)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_dly_q),
    .push_data (bus.fifo_dout),
    .pop       (pop),
    .head_data (head),
    .occ       (occ)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      assert (occ_sum <= 3'(OB_DEPTH));
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop && !(&beat_cnt_q))
      beat_cnt_d = beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      beat_cnt_q <= '0;
    else
      beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`else
  // Stats build option disabled: no counter, no beat_cnt port.
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: FIFO source model feeds words, monitor checks stream.
module tb_fifo_rd_stream;

  localparam int DW = 8;
`ifdef FIFO_RD_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_rd_stream_if #(.DW(DW)) bus ();

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] beat_cnt;
`endif

  fifo_rd_stream #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef FIFO_RD_STATS_EN
    .beat_cnt (beat_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rd_cnt = 0;
  int  beats = 0;
  int  beats_rst = 0;
  int  first_beat = -1;
  int  last_beat = -1;
  bit  rd_seen = 0;
  bit  rdy_force = 1;
  bit  rdy_rand = 0;
  bit  gap_en = 0;
  bit  rst_prev = 0;
  bit  stall_prev = 0;
  logic [DW-1:0] stall_data;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, req, $time);
    end
  endtask

  // FIFO source model: data appears the cycle after an accepted read.
  always @(negedge clk) begin
    if (rd_seen && src.size() > 0)
      bus.fifo_dout = src.pop_front();
    else
      bus.fifo_dout = DW'($urandom);
    rd_seen = 0;
    bus.fifo_empty = (src.size() == 0)
                  || (gap_en && $urandom_range(3) == 0);
    bus.m_ready = rdy_rand ? 1'($urandom_range(1)) : rdy_force;
  end

  // Monitor: samples just after inputs settle for the coming edge.
  always @(negedge clk) begin
    logic [DW-1:0] want;
    longint        sat;
    #2;
    if (rst) begin
      chk(!bus.fifo_rd, "rd_in_rst", bus.fifo_rd, 0);
      if (rst_prev) begin
        chk(!bus.m_valid, "valid_in_rst", bus.m_valid, 0);
        chk(bus.m_data == '0, "data_in_rst", bus.m_data, 0);
`ifdef FIFO_RD_STATS_EN
        chk(beat_cnt == '0, "cnt_in_rst", beat_cnt, 0);
`endif
      end
      stall_prev = 0;
    end else begin
`ifdef FIFO_RD_STATS_EN
      sat = (1 << CNT_W) - 1;
      if (beats_rst < sat) sat = beats_rst;
      chk(beat_cnt == CNT_W'(sat), "beat_cnt", beat_cnt, sat);
`endif
      if (bus.fifo_rd) begin
        chk(!bus.fifo_empty, "rd_when_empty", bus.fifo_empty, 0);
        rd_seen = 1;
        rd_cnt++;
      end
      if (stall_prev)
        chk(bus.m_valid && bus.m_data == stall_data, "hold",
            bus.m_data, stall_data);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_beat", bus.m_data, 0);
        end else begin
          want = exp_q.pop_front();
          chk(bus.m_data == want, "beat_data", bus.m_data, want);
        end
        beats++;
        beats_rst++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end
    rst_prev = rst;
  end

  task automatic load(input logic [DW-1:0] w);
    src.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int b0, rd0;
    bus.fifo_empty = 1'b1;
    bus.m_ready    = 1'b0;
    bus.fifo_dout  = '0;

    // Reset with a non-empty FIFO holding one word.
    load(8'hA5);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #3;
    chk(bus.fifo_rd, "first_rd", bus.fifo_rd, 1);
    @(negedge clk); #3;
    chk(!bus.m_valid, "lat_t1", bus.m_valid, 0);
    @(negedge clk); #3;
    chk(bus.m_valid, "lat_t2_valid", bus.m_valid, 1);
    chk(bus.m_data == 8'hA5, "lat_t2_data", bus.m_data, 8'hA5);
    @(negedge clk); #3;
    chk(!bus.m_valid, "single_pulse", bus.m_valid, 0);
    chk(rd_cnt == 1, "single_rd_cnt", rd_cnt, 1);
    repeat (3) @(negedge clk);

    // Streaming 64 words at full rate.
    b0 = beats;
    first_beat = -1;
    for (int i = 0; i < 64; i++) load(DW'(i));
    wait_drain(300);
    chk(beats - b0 == 64, "stream_beats", beats - b0, 64);
    chk(last_beat - first_beat == 63, "stream_gapless",
        last_beat - first_beat, 63);

    // Backpressure: buffer fills to 3, head held, then drain gapless.
    rdy_force = 0;
    rd0 = rd_cnt;
    for (int i = 0; i < 10; i++) load(DW'(8'h80 + i));
    repeat (12) @(negedge clk);
    #3;
    chk(rd_cnt - rd0 == 3, "bp_reads", rd_cnt - rd0, 3);
    chk(bus.m_valid, "bp_valid", bus.m_valid, 1);
    chk(bus.m_data == 8'h80, "bp_head", bus.m_data, 8'h80);
    first_beat = -1;
    rdy_force = 1;
    wait_drain(200);
    chk(last_beat - first_beat == 9, "bp_gapless",
        last_beat - first_beat, 9);

    // Random ready and random empty gaps, 1000 words.
    gap_en = 1;
    rdy_rand = 1;
    b0 = beats;
    for (int i = 0; i < 1000; i++) load(DW'($urandom));
    wait_drain(20000);
    chk(beats - b0 == 1000, "rand_beats", beats - b0, 1000);
    gap_en = 0;
    rdy_rand = 0;
    rdy_force = 1;

    // Reset mid-operation with a full buffer; FIFO reset alongside.
    rdy_force = 0;
    for (int i = 0; i < 6; i++) load(DW'(8'h40 + i));
    repeat (8) @(negedge clk);
    rst = 1'b1;
    src.delete();
    exp_q.delete();
    rd_seen = 0;
    beats_rst = 0;
    repeat (3) @(negedge clk);
    #3;
    chk(!bus.m_valid, "rst_flush", bus.m_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    rdy_force = 1;
    repeat (3) @(negedge clk);
    #3;
    chk(!bus.m_valid, "post_rst_idle", bus.m_valid, 0);
    load(8'h3C);
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
